// File: rtl/ram_pkg.sv
// Shared types and helpers for the multi-cycle data RAM.
//   state_e     : access sequencer states
//   region_e    : address-window classification of a word index
//   BYTE_OFS_W  : byte-offset bits below the word index
//   word_index  : byte address -> word index
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REG_IN  = 2'd0,
    REG_OUT = 2'd1,
    REG_RAM = 2'd2,
    REG_ERR = 2'd3
  } region_e;

  localparam int unsigned BYTE_OFS_W = 2;

  // Addresses are widened to this before decode so the helper is width-agnostic.
  localparam int unsigned ADDR_MAX_W = 64;

  function automatic logic [ADDR_MAX_W-1:0] word_index(input logic [ADDR_MAX_W-1:0] addr);
    return addr >> BYTE_OFS_W;
  endfunction

endpackage : ram_pkg

// File: rtl/ram_io_bank.sv
// User I/O window: output-channel registers, byte-strobe merge and I/O read mux.
// Optional feature macro: RAM_BYTE_STROBE_EN (byte-gated writes when defined).
// Ports:
//   clock, reset  : clock, asynchronous active-high reset
//   wr_en         : commit a write to output channel ch this edge
//   ch            : channel index (input or output channel depending on rd_in)
//   wdata, wstrb  : write data and byte enables
//   rd_in         : 1 = read usr_in[ch], 0 = read usr_out[ch]
//   rdata_c       : combinational read data for the selected channel
//   wmask_c       : combinational bit mask derived from wstrb (shared with RAM)
//   usr_in        : asynchronous user inputs, channel 0 in the LSBs
//   usr_out       : registered user outputs, channel 0 in the LSBs
module ram_io_bank
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IO_CH  = 2,
  localparam int unsigned CH_W   = (IO_CH > 1) ? $clog2(IO_CH) : 1,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [CH_W-1:0]           ch,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [STRB_W-1:0]         wstrb,
  input  logic                      rd_in,
  output logic [DATA_W-1:0]         rdata_c,
  output logic [DATA_W-1:0]         wmask_c,
  input  logic [IO_CH*DATA_W-1:0]   usr_in,
  output logic [IO_CH*DATA_W-1:0]   usr_out
);

  // Byte-enable expansion; without strobes every write covers the full word.
`ifdef RAM_BYTE_STROBE_EN
  always_comb begin
    wmask_c = '0;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      wmask_c[i*8 +: 8] = {8{wstrb[i]}};
    end
  end
`else
  always_comb begin
    wmask_c = '1;
  end

  logic unused_wstrb;
  assign unused_wstrb = ^wstrb;
`endif

  // Read mux across the I/O window.
  always_comb begin
    rdata_c = '0;
    if (rd_in) begin
      rdata_c = usr_in[32'(ch)*DATA_W +: DATA_W];
    end else begin
      rdata_c = usr_out[32'(ch)*DATA_W +: DATA_W];
    end
  end

  // Output-channel registers with strobe merge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      usr_out <= '0;
    end else if (wr_en) begin
      usr_out[32'(ch)*DATA_W +: DATA_W] <=
        (usr_out[32'(ch)*DATA_W +: DATA_W] & ~wmask_c) | (wdata & wmask_c);
    end
  end

endmodule : ram_io_bank

// File: rtl/multi_cycle_ram.sv
// Multi-cycle word-organised data RAM with request/response handshake,
// fixed access latency, memory-mapped user I/O window and error reporting.
// Optional feature macro: RAM_BYTE_STROBE_EN (byte-gated writes when defined).
// Ports:
//   clock, reset                 : clock, asynchronous active-high reset
//   req_valid/req_ready          : request handshake (accept when both high)
//   req_write, req_addr          : direction and byte address (word aligned)
//   req_wdata, req_wstrb         : write data and byte enables
//   resp_valid                   : one-cycle response pulse
//   resp_rdata, resp_err         : read data (0 for writes/errors), error flag
//   usr_in, usr_out              : packed user I/O channels, channel 0 in LSBs
module multi_cycle_ram
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IO_CH       = 2,
  parameter int unsigned LATENCY     = 2,
  localparam int unsigned STRB_W = DATA_W / 8,
  localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1,
  localparam int unsigned CH_W   = (IO_CH > 1) ? $clog2(IO_CH) : 1,
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  input  logic [STRB_W-1:0]       req_wstrb,
  output logic                    resp_valid,
  output logic [DATA_W-1:0]       resp_rdata,
  output logic                    resp_err,
  input  logic [IO_CH*DATA_W-1:0] usr_in,
  output logic [IO_CH*DATA_W-1:0] usr_out
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [STRB_W-1:0] lat_wstrb;

  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [STRB_W-1:0] acc_wstrb;

  logic [ADDR_MAX_W-1:0] acc_idx;
  region_e           region;
  logic [CH_W-1:0]   io_ch;
  logic [IDX_W-1:0]  ram_idx;

  logic              do_access;
  logic              io_wr_en;
  logic              ram_we;
  logic [DATA_W-1:0] io_rdata;
  logic [DATA_W-1:0] wmask;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture at the acceptance edge (ready is high exactly in IDLE).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
    end else if (state_q == IDLE && req_valid) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_wstrb <= req_wstrb;
    end
  end

  // With LATENCY=1 the access happens on the acceptance edge itself, so the
  // live request is used; otherwise the captured copy.
  always_comb begin
    if (state_q == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wstrb = req_wstrb;
    end else begin
      acc_write = lat_write;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_wstrb = lat_wstrb;
    end
  end

  // Region decode of the access address.
  always_comb begin
    acc_idx = word_index(ADDR_MAX_W'(acc_addr));
    region  = REG_RAM;
    if (acc_addr[BYTE_OFS_W-1:0] != '0 || acc_idx >= ADDR_MAX_W'(DEPTH_WORDS)) begin
      region = REG_ERR;
    end else if (acc_idx < ADDR_MAX_W'(IO_CH)) begin
      region = REG_IN;
    end else if (acc_idx < ADDR_MAX_W'(2 * IO_CH)) begin
      region = REG_OUT;
    end
    io_ch   = (region == REG_OUT) ? CH_W'(acc_idx - ADDR_MAX_W'(IO_CH)) : CH_W'(acc_idx);
    ram_idx = IDX_W'(acc_idx);
  end

  // DONE is only ever entered from IDLE or WAIT, so this marks the commit edge.
  assign do_access = (state_d == DONE);
  assign io_wr_en  = do_access && acc_write && (region == REG_OUT);
  assign ram_we    = do_access && acc_write && (region == REG_RAM);

  ram_io_bank #(
    .DATA_W (DATA_W),
    .IO_CH  (IO_CH)
  ) u_io_bank (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (io_wr_en),
    .ch      (io_ch),
    .wdata   (acc_wdata),
    .wstrb   (acc_wstrb),
    .rd_in   (region == REG_IN),
    .rdata_c (io_rdata),
    .wmask_c (wmask),
    .usr_in  (usr_in),
    .usr_out (usr_out)
  );

  // Backing storage; the I/O-window words of the array are never addressed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem <= '{default: '0};
    end else if (ram_we) begin
      mem[ram_idx] <= (mem[ram_idx] & ~wmask) | (acc_wdata & wmask);
    end
  end

  // Response data: zero for writes and errors.
  always_comb begin
    rd_word = '0;
    if (!acc_write) begin
      unique case (region)
        REG_IN, REG_OUT: rd_word = io_rdata;
        REG_RAM:         rd_word = mem[ram_idx];
        default:         rd_word = '0;
      endcase
    end
  end

  // Registered handshake and response outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      req_ready  <= (state_d == IDLE);
      resp_valid <= (state_d == DONE);
      if (do_access) begin
        resp_err   <= (region == REG_ERR);
        resp_rdata <= rd_word;
      end
    end
  end

endmodule : multi_cycle_ram

// File: tb/tb_multi_cycle_ram.sv
// Scoreboard bench for multi_cycle_ram: the driver queues the expected
// response at each acceptance edge, a monitor checks every response pulse.
module tb_multi_cycle_ram;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned NCH   = 2;
  localparam int unsigned LAT   = 2;
  localparam int unsigned PER   = 10;

  logic            clock = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_wstrb;
  logic            resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic            resp_err;
  logic [NCH*DW-1:0] usr_in;
  logic [NCH*DW-1:0] usr_out;

  multi_cycle_ram #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .DEPTH_WORDS (DEPTH),
    .IO_CH       (NCH),
    .LATENCY     (LAT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .usr_in     (usr_in),
    .usr_out    (usr_out)
  );

  always #(PER/2) clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    time         t_acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   resp_pulses = 0;
  logic after_done = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Response monitor.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      after_done = 1'b0;
    end else begin
      if (resp_valid) resp_pulses++;
      if (after_done) begin
        check("ready_after_done", 32'(req_ready), 32'd1);
        check("resp_single_pulse", 32'(resp_valid), 32'd0);
        after_done = 1'b0;
      end else if (resp_valid) begin
        check("ready_in_done", 32'(req_ready), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", 32'(resp_err), 32'(e.err));
          check("latency", 32'($time - e.t_acc), 32'(LAT*PER + PER/2));
        end
        after_done = 1'b1;
      end else if (exp_q.size() != 0) begin
        check("ready_in_wait", 32'(req_ready), 32'd0);
      end
    end
  end

  // Issue one transaction, then present junk while busy (must be ignored).
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] er, input logic ee);
    exp_t e;
    int n;
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clock); n++; end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    e.rdata = er; e.err = ee; e.t_acc = $time;
    exp_q.push_back(e);
    @(negedge clock);
    req_write = ~w; req_addr = 32'h44; req_wdata = 32'h5A5A_5A5A; req_wstrb = 4'hF;
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clock); n++; end
    if (exp_q.size() != 0) begin
      check("resp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #(200000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ram40;
    logic [31:0] ch1_exp;
    int p0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0;
    usr_in = {32'h1234_5678, 32'hCAFE_0001};
    @(negedge clock); @(negedge clock);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_usr_out0", usr_out[31:0], 32'd0);
    check("rst_usr_out1", usr_out[63:32], 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // Basic read of an untouched RAM word.
    txn(1'b0, 32'h28, 32'h0, 4'h0, 32'h0, 1'b0);

    // Full write then read back.
    txn(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    ram40 = 32'hDEAD_BEEF;
    txn(1'b0, 32'h40, 32'h0, 4'h0, ram40, 1'b0);

    // Strobed write over DEADBEEF.
    txn(1'b1, 32'h40, 32'h1122_3344, 4'h5, 32'h0, 1'b0);
`ifdef RAM_BYTE_STROBE_EN
    ram40 = 32'hDE22_BE44;
`else
    ram40 = 32'h1122_3344;
`endif
    txn(1'b0, 32'h40, 32'h0, 4'h0, ram40, 1'b0);

    // Zero-strobe write.
    txn(1'b1, 32'h40, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
`ifndef RAM_BYTE_STROBE_EN
    ram40 = 32'hFFFF_FFFF;
`endif
    txn(1'b0, 32'h40, 32'h0, 4'h0, ram40, 1'b0);

    // Output channel 0 write and read back.
    txn(1'b1, 32'h8, 32'h0000_00A5, 4'hF, 32'h0, 1'b0);
    check("usr_out0_after_write", usr_out[31:0], 32'h0000_00A5);
    txn(1'b0, 32'h8, 32'h0, 4'h0, 32'h0000_00A5, 1'b0);

    // Write to input channel 0 is dropped without error.
    txn(1'b1, 32'h0, 32'h0000_0055, 4'hF, 32'h0, 1'b0);
    check("usr_out0_in_write", usr_out[31:0], 32'h0000_00A5);
    check("usr_out1_in_write", usr_out[63:32], 32'h0);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0);
    txn(1'b0, 32'h4, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
    usr_in[63:32] = 32'h0BAD_CAFE;
    txn(1'b0, 32'h4, 32'h0, 4'h0, 32'h0BAD_CAFE, 1'b0);

    // Strobed write to output channel 1 (previously 0).
    txn(1'b1, 32'hC, 32'hAABB_CCDD, 4'h3, 32'h0, 1'b0);
`ifdef RAM_BYTE_STROBE_EN
    ch1_exp = 32'h0000_CCDD;
`else
    ch1_exp = 32'hAABB_CCDD;
`endif
    check("usr_out1_strobe", usr_out[63:32], ch1_exp);
    txn(1'b0, 32'hC, 32'h0, 4'h0, ch1_exp, 1'b0);

    // Error accesses.
    txn(1'b0, 32'h41, 32'h0, 4'h0, 32'h0, 1'b1);
    txn(1'b0, 32'(4*DEPTH), 32'h0, 4'h0, 32'h0, 1'b1);
    txn(1'b1, 32'h41, 32'h1357_9BDF, 4'hF, 32'h0, 1'b1);
    txn(1'b1, 32'(4*DEPTH), 32'h2468_ACE0, 4'hF, 32'h0, 1'b1);
    txn(1'b1, 32'h9, 32'h0000_0000, 4'hF, 32'h0, 1'b1);
    check("usr_out0_after_err", usr_out[31:0], 32'h0000_00A5);
    txn(1'b0, 32'h40, 32'h0, 4'h0, ram40, 1'b0);

    // Boundary RAM words.
    txn(1'b1, 32'(4*DEPTH - 4), 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0);
    txn(1'b0, 32'(4*DEPTH - 4), 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0);
    txn(1'b1, 32'h10, 32'h7654_3210, 4'hF, 32'h0, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'h7654_3210, 1'b0);

    // Reset during WAIT aborts the pending write.
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40;
    req_wdata = 32'h7777_7777; req_wstrb = 4'hF;
    check("abort_ready_before", 32'(req_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    p0 = resp_pulses;
    check("abort_ready_wait", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("abort_ready_in_rst", 32'(req_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("abort_no_resp", 32'(resp_pulses - p0), 32'd0);
    check("abort_ready_after", 32'(req_ready), 32'd1);
    check("abort_usr_out0", usr_out[31:0], 32'd0);
    txn(1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b0);

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_multi_cycle_ram
